// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared load/store size codes (also used by decoder_riscv), the
//            load/store unit state type and small access-legality helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Codes 3, 6 and 7 have no meaning for a 32-bit data port.
  function automatic logic size_legal(input logic [2:0] size);
    case (size)
      LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  // Byte accesses can never straddle a word, so only H/HU/W are checked.
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] low);
    case (size)
      LDST_H, LDST_HU: return low[0];
      LDST_W:          return |low;
      default:         return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_extend
// Purpose  : Picks the addressed byte/half out of a read word and sign- or
//            zero-extends it to 32 bits according to the load size.
// Ports    : rdata_i   [31:0] captured memory word
//            offset_i  [1:0]  byte offset of the access within the word
//            size_i    [2:0]  LDST_* size code
//            core_rd_o [31:0] extended load result
// Revision : 1.0 - initial release
// ============================================================================
module lsu_load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  size_i,
  output logic [31:0] core_rd_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    // Halves are 2-byte aligned, so only offset bit 1 picks the half.
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (size_i)
      LDST_B:  core_rd_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: core_rd_o = {24'd0, byte_sel};
      LDST_H:  core_rd_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: core_rd_o = {16'd0, half_sel};
      default: core_rd_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : riscv_lsu
// Purpose  : Load/store unit between the core data port and data memory.
//            Issues word-aligned requests with byte enables and replicated
//            store data, stalls the core while memory is busy, returns the
//            extended load result and flags misaligned/illegal-size accesses.
// Ports    : clk_i, rst_i (sync, active high)
//            core_req_i/we_i/size_i/addr_i/wd_i  core request
//            core_rd_o, core_stall_o, core_fault_o  responses to core
//            mem_req_o/we_o/be_o/addr_o/wd_o       memory request
//            mem_rd_i, mem_ready_i                 memory response
// Revision : 1.0 - initial release
// ============================================================================
module riscv_lsu
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  lsu_state_t  state_q;
  logic [31:0] rdata_q;
  logic [1:0]  offset_q;
  logic [2:0]  size_q;

  logic access_bad;
  logic start;

  assign access_bad = !size_legal(core_size_i) || misaligned(core_size_i, core_addr_i[1:0]);

  // A new access is only accepted in IDLE; DONE ignores core_req_i so the
  // instruction still presented by the core is not issued a second time.
  assign start = (state_q == IDLE) && core_req_i && !access_bad;

  // The core holds its request stable under stall, so the memory side is
  // driven straight from the core inputs in both IDLE and BUSY.
  assign mem_req_o    = !rst_i && (start || (state_q == BUSY));
  assign core_stall_o = mem_req_o;
  assign core_fault_o = !rst_i && (state_q == IDLE) && core_req_i && access_bad;
  assign mem_we_o     = mem_req_o && core_we_i;
  assign mem_addr_o   = {core_addr_i[31:2], 2'b00};

  always_comb begin
    mem_be_o = 4'b1111;
    mem_wd_o = core_wd_i;
    if (core_we_i) begin
      case (core_size_i[1:0])
        2'd0: begin
          mem_be_o = 4'b0001 << core_addr_i[1:0];
          mem_wd_o = {4{core_wd_i[7:0]}};
        end
        2'd1: begin
          mem_be_o = 4'b0011 << core_addr_i[1:0];
          mem_wd_o = {2{core_wd_i[15:0]}};
        end
        default: begin
          mem_be_o = 4'b1111;
          mem_wd_o = core_wd_i;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rdata_q  <= 32'd0;
      offset_q <= 2'd0;
      size_q   <= LDST_W;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            size_q   <= core_size_i;
            offset_q <= core_addr_i[1:0];
            if (mem_ready_i) begin
              rdata_q <= mem_rd_i;
              state_q <= DONE;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (mem_ready_i) begin
            rdata_q <= mem_rd_i;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  lsu_load_extend u_load_extend (
    .rdata_i   (rdata_q),
    .offset_i  (offset_q),
    .size_i    (size_q),
    .core_rd_o (core_rd_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_lsu
// Purpose  : Self-checking bench for riscv_lsu: directed scenarios followed by
//            random accesses compared against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr;
  logic [31:0] core_wd;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        core_fault;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_lsu dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .core_req_i   (core_req),
    .core_we_i    (core_we),
    .core_size_i  (core_size),
    .core_addr_i  (core_addr),
    .core_wd_i    (core_wd),
    .core_rd_o    (core_rd),
    .core_stall_o (core_stall),
    .core_fault_o (core_fault),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_be_o     (mem_be),
    .mem_addr_o   (mem_addr),
    .mem_wd_o     (mem_wd),
    .mem_rd_i     (mem_rd),
    .mem_ready_i  (mem_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (access-level arithmetic) -------------
  function automatic int nbytes(input logic [2:0] size);
    case (size)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit is_fault(input logic [2:0] size, input logic [31:0] addr);
    int n;
    n = nbytes(size);
    if (n == 0) return 1'b1;
    return (addr % n) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic we, input logic [2:0] size, input logic [31:0] addr);
    int m;
    if (!we) return 4'b1111;
    m = ((1 << nbytes(size)) - 1) << (addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] size, input logic [31:0] wd);
    case (nbytes(size))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [2:0] size, input logic [31:0] addr);
    logic [31:0] v;
    v = word >> ((addr % 4) * 8);
    case (size)
      3'd0: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v + 32'hFFFF_FF00; end
      3'd4: v = v & 32'hFF;
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v + 32'hFFFF_0000; end
      3'd5: v = v & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  // One complete core access. Entered shortly after a rising edge with the
  // unit idle; returns shortly after a rising edge with the unit idle again.
  // delay = number of cycles the memory waits before asserting ready.
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdw, input int delay,
                        input bit ready_in_done);
    core_req  = 1'b1;
    core_we   = we;
    core_size = size;
    core_addr = addr;
    core_wd   = wd;
    if (is_fault(size, addr)) begin
      mem_ready = 1'($urandom_range(1));
      mem_rd    = $urandom;
      #1;
      chk("fault_flag", 32'(core_fault), 32'd1);
      chk("fault_req", 32'(mem_req), 32'd0);
      chk("fault_stall", 32'(core_stall), 32'd0);
      @(posedge clk); #1;
      core_req  = 1'b0;
      mem_ready = 1'b0;
      #1;
      chk("fault_clear", 32'(core_fault), 32'd0);
      chk("fault_idle_req", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
      return;
    end
    for (int i = 0; i <= delay; i++) begin
      mem_ready = (i == delay);
      mem_rd    = (i == delay) ? rdw : $urandom;
      #1;
      chk("req", 32'(mem_req), 32'd1);
      chk("stall", 32'(core_stall), 32'd1);
      chk("nofault", 32'(core_fault), 32'd0);
      chk("addr", mem_addr, addr & 32'hFFFF_FFFC);
      chk("we", 32'(mem_we), 32'(we));
      chk("be", 32'(mem_be), 32'(exp_be(we, size, addr)));
      if (we) chk("wd", mem_wd, exp_wd(size, wd));
      @(posedge clk); #1;
    end
    // Commit cycle: the core still presents the same request, which must
    // not be reissued.
    mem_ready = ready_in_done;
    mem_rd    = $urandom;
    #1;
    chk("done_stall", 32'(core_stall), 32'd0);
    chk("done_req", 32'(mem_req), 32'd0);
    chk("done_fault", 32'(core_fault), 32'd0);
    if (!we) chk("load_data", core_rd, exp_load(rdw, size, addr));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] sz;
    rst       = 1'b1;
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_size = 3'd2;
    core_addr = 32'h40;
    core_wd   = 32'd0;
    mem_rd    = 32'd0;
    mem_ready = 1'b1;

    // Reset: outputs quiet even with a request pending.
    @(posedge clk); #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_fault", 32'(core_fault), 32'd0);
    @(posedge clk); #1;
    rst       = 1'b0;
    core_req  = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("rst_rd", core_rd, 32'd0);
    chk("idle_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;

    // LB 0x103, ready after 2 extra cycles.
    access(1'b0, 3'd0, 32'h103, 32'd0, 32'h80FF_1234, 2, 1'b0);
    // LHU 0x102, ready immediately.
    access(1'b0, 3'd5, 32'h102, 32'd0, 32'h8001_0000, 0, 1'b0);
    // SB 0x201, SH 0x202.
    access(1'b1, 3'd0, 32'h201, 32'h0000_00AB, 32'd0, 1, 1'b0);
    access(1'b1, 3'd1, 32'h202, 32'h0000_1234, 32'd0, 0, 1'b0);
    // Misaligned LW and illegal size.
    access(1'b0, 3'd2, 32'h101, 32'd0, 32'd0, 0, 1'b0);
    access(1'b0, 3'd3, 32'h100, 32'd0, 32'd0, 0, 1'b0);

    // Reset while BUSY.
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_size = 3'd2;
    core_addr = 32'h80;
    mem_ready = 1'b0;
    #1;
    chk("pre_busy_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    chk("busy_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("busy_rst_req", 32'(mem_req), 32'd0);
    chk("busy_rst_stall", 32'(core_stall), 32'd0);
    @(posedge clk); #1;
    rst       = 1'b0;
    core_req  = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("post_rst_req", 32'(mem_req), 32'd0);
    chk("post_rst_stall", 32'(core_stall), 32'd0);
    chk("post_rst_rd", core_rd, 32'd0);
    @(posedge clk); #1;
    access(1'b0, 3'd2, 32'h0, 32'd0, 32'hCAFE_F00D, 0, 1'b0);

    // Back-to-back LWs with ready held high throughout.
    access(1'b0, 3'd2, 32'h10, 32'd0, 32'h1111_0010, 0, 1'b1);
    access(1'b0, 3'd2, 32'h14, 32'd0, 32'h2222_0014, 0, 1'b1);

    // Random accesses.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(9))
        0:       sz = 3'(3 + 3 * $urandom_range(1) + $urandom_range(1));
        1, 2:    sz = 3'd0;
        3, 4:    sz = 3'd1;
        5, 6:    sz = 3'd2;
        7:       sz = 3'd4;
        default: sz = 3'd5;
      endcase
      access(1'($urandom_range(1)), sz, $urandom, $urandom, $urandom,
             int'($urandom_range(3)), 1'($urandom_range(1)));
      if ($urandom_range(3) == 0) begin
        core_req  = 1'b0;
        mem_ready = 1'($urandom_range(1));
        #1;
        chk("gap_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
